arb8_rr: RTL and testbench

Eight-way round-robin arbiter that shares one resource (a shared bus or RAM port) among eight requesters. It uses the `_or8way` gate as its any-request detector. Grants are registered, one-hot and held for as long as the winning requester keeps its request asserted. Priority rotates so that every persistent requester is served within eight grant tenures.

---
 rtl/arb8_rr.sv | 131 +++++++++++++
 tb/tb_arb8_rr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/arb8_rr.sv
// arb8_rr: eight-way round-robin arbiter, registered one-hot grant.
// Macro ARB_TIMEOUT_EN adds a MAX_HOLD tenure limit with a preempt pulse.

// Any-request detector: plain 8-input OR
module _or8way (
  input  logic [7:0] i_in,
  output logic       o_out
);
  assign o_out = |i_in;
endmodule

module arb8_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       any_req,
  output logic       preempt
);
  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      r_state;
  logic [7:0]  r_grant;
  logic [2:0]  r_grant_id;
  logic        r_valid;
  logic [2:0]  r_ptr;

  logic        w_any;
  logic [15:0] w_dbl;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;
  logic [2:0]  w_win;
  logic        w_hold;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("arb8_rr: MAX_HOLD must be within 2..255");
  end

  _or8way u_any (
    .i_in  (req),
    .o_out (w_any)
  );

  // Rotate so that bit 0 is the requester at the priority pointer
  assign w_dbl  = {req, req} >> r_ptr;
  assign w_rot  = w_dbl[7:0];
  assign w_win  = w_off + r_ptr;
  assign w_hold = req[r_grant_id];

  // Lowest set bit of the rotated vector is the winner's offset
  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt;
  logic       r_preempt;
`endif

  // IDLE/GRANT state machine with registered grant outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= 8'd0;
      r_grant_id <= 3'd0;
      r_valid    <= 1'b0;
      r_ptr      <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= 8'd0;
      r_preempt  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_preempt <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= GRANT;
            r_grant    <= 8'd1 << w_win;
            r_grant_id <= w_win;
            r_valid    <= 1'b1;
            r_ptr      <= w_win + 3'd1;
`ifdef ARB_TIMEOUT_EN
            r_cnt      <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (!w_hold) begin
            r_state <= IDLE;
            r_grant <= 8'd0;
            r_valid <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == HOLD_LAST) begin
            r_state   <= IDLE;
            r_grant   <= 8'd0;
            r_valid   <= 1'b0;
            r_preempt <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_valid;
  assign any_req     = w_any;
`ifdef ARB_TIMEOUT_EN
  assign preempt     = r_preempt;
`else
  assign preempt     = 1'b0;
`endif

endmodule

// File: tb/tb_arb8_rr.sv
// tb_arb8_rr: directed stimulus, per-cycle model compare, literal checks.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_arb8_rr;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       any_req;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // model: who holds the bus (-1 none), visible tenure length, pointer
  int m_holder = -1;
  int m_seen = 0;
  int m_ptr = 0;
  bit m_pre = 1'b0;

  arb8_rr #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .any_req     (any_req),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model, advanced on each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_holder = -1;
        m_seen = 0;
        m_ptr = 0;
        m_pre = 1'b0;
      end else if (m_holder < 0) begin
        m_pre = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (m_holder < 0 && req[(m_ptr + k) % 8]) m_holder = (m_ptr + k) % 8;
        end
        if (m_holder >= 0) begin
          m_ptr = (m_holder + 1) % 8;
          m_seen = 1;
        end
      end else begin
        m_pre = 1'b0;
        if (!req[m_holder]) begin
          m_holder = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_seen == MH) begin
          m_holder = -1;
          m_pre = 1'b1;
        end
`endif
        else begin
          m_seen++;
        end
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("grant", int'(grant), m_holder < 0 ? 0 : (1 << m_holder));
        chk("grant_valid", int'(grant_valid), m_holder >= 0 ? 1 : 0);
        if (m_holder >= 0) chk("grant_id", int'(grant_id), m_holder);
        chk("any_req", int'(any_req), req != 8'd0 ? 1 : 0);
        chk("preempt", int'(preempt), int'(m_pre));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with all requesting
    req = 8'hFF;
    reset = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_preempt", int'(preempt), 0);
    reset = 1'b1;
    step();
    chk("first_grant", int'(grant), 8'h01);
    chk("first_id", int'(grant_id), 0);

    // rotation 0..7,0 with one idle cycle between tenures
    for (int k = 0; k < 9; k++) begin
      chk("rot_id", int'(grant_id), k % 8);
      chk("rot_valid", int'(grant_valid), 1);
      step();
      chk("rot_hold", int'(grant_id), k % 8);
      req[k % 8] = 1'b0;
      step();
      chk("rot_gap", int'(grant), 0);
      if (k < 8) begin
        req = 8'hFF;
        step();
      end
    end

    // empty
    req = 8'h00;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("empty_grant", int'(grant), 0);
      chk("empty_any", int'(any_req), 0);
    end
    req = 8'h80;
    #1;
    chk("any_comb", int'(any_req), 1);
    step();
    chk("top_grant", int'(grant), 8'h80);
    chk("top_id", int'(grant_id), 7);
    req = 8'h00;
    step();

    // wrap and skip: tenure for 5 leaves ptr at 6
    req = 8'h20;
    step();
    chk("g5_id", int'(grant_id), 5);
    req = 8'h00;
    step();
    req = 8'b0001_0010;
    step();
    chk("wrap_id", int'(grant_id), 1);
    req = 8'b0001_0000;
    step();
    chk("wrap_gap", int'(grant), 0);
    step();
    chk("skip_id", int'(grant_id), 4);
    req = 8'h00;
    step();

    // mid-tenure reset
    req = 8'h08;
    step();
    chk("g3_id", int'(grant_id), 3);
    req = 8'h0A;
    reset = 1'b0;
    step();
    chk("mrst_grant", int'(grant), 0);
    chk("mrst_preempt", int'(preempt), 0);
    reset = 1'b1;
    step();
    chk("post_rst_id", int'(grant_id), 1);
    req = 8'h00;
    step();

    // ptr is now 2; requester 2 holds permanently alongside 3
    req = 8'h0C;
    step();
    chk("hold_id", int'(grant_id), 2);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < MH; k++) begin
      step();
      chk("to_hold", int'(grant), 8'h04);
    end
    step();
    chk("to_grant", int'(grant), 0);
    chk("to_preempt", int'(preempt), 1);
    step();
    chk("to_next_id", int'(grant_id), 3);
    chk("to_pulse_end", int'(preempt), 0);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("starve_grant", int'(grant), 8'h04);
      chk("starve_preempt", int'(preempt), 0);
    end
`endif
    req = 8'h00;
    step();
    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
